// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants for the unified-memory arbiter.
//   FSM state codes (IDLE/ISSUE/WAIT), owner codes (IF=0, DM=1),
//   default latency / starvation limits, counter widths and a saturating
//   increment helper for the starvation counter.
package mem_arb_pkg;

  localparam int unsigned MEM_LAT_DEF    = 2;
  localparam int unsigned STARVE_MAX_DEF = 4;
  localparam int unsigned LAT_CNT_W      = 3;
  localparam int unsigned STARVE_W       = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  // Increment that sticks at lim.
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                  input logic [STARVE_W-1:0] lim);
    return (v >= lim) ? lim : v + STARVE_W'(1);
  endfunction

endpackage

// File: rtl/mem_arb_lat_timer.sv
// mem_arb_lat_timer: loadable 3-bit read-latency counter.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   load       : count <= 1 (leaving ISSUE for a read)
//   inc        : count <= count + 1 (waiting)
//   neither    : count <= 0
//   done_c     : count == MEM_LAT (read data valid this cycle)
//   pre_done_c : count == MEM_LAT-1 (read data valid next cycle)
module mem_arb_lat_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic done_c,
  output logic pre_done_c
);

  logic [LAT_CNT_W-1:0] cnt;

  // Latency count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LAT_CNT_W'(1);
    end else if (inc) begin
      cnt <= cnt + LAT_CNT_W'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign done_c     = (cnt == LAT_CNT_W'(MEM_LAT));
  assign pre_done_c = (cnt == LAT_CNT_W'(MEM_LAT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a single-port fixed-latency memory between the
// fetch stage (IF, read-only) and the MEM stage (DM, read/write).
//   if_req/if_addr -> if_rdy/if_rdata         fetch port
//   dm_re/dm_we/dm_addr/dm_wdata -> dm_rdy/dm_rdata   data port
//   mem_addr/mem_re/mem_we/mem_wdata/mem_rdata        memory macro
//   stall_if/stall_mem                        combinational pipeline stalls
// Optional macro MEM_ARB_PERF_EN adds perf_if_stall/perf_dm_stall
// saturating stall-cycle counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rdy,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_re,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_rdy,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
`ifdef MEM_ARB_PERF_EN
  output logic [15:0]       perf_if_stall,
  output logic [15:0]       perf_dm_stall,
`endif
  output logic              stall_mem
);

  logic [1:0]          state_q, state_d;
  logic                own_q, own_d;
  logic                wr_q, wr_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                re_d, we_d, if_rdy_d, dm_rdy_d;
  logic                tmr_load, tmr_inc, tmr_done_c, tmr_pre_done_c;

  logic dm_req_c, completing_c, decide_c, if_pend_c, dm_pend_c;
  logic gnt_if_c, gnt_dm_c, rd_fin_c;

  mem_arb_lat_timer #(.MEM_LAT(MEM_LAT)) u_lat_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (tmr_load),
    .inc        (tmr_inc),
    .done_c     (tmr_done_c),
    .pre_done_c (tmr_pre_done_c)
  );

  assign dm_req_c = dm_re | dm_we;

  // A write completes in its ISSUE cycle, a read when the timer reaches MEM_LAT.
  assign completing_c = ((state_q == ST_ISSUE) && wr_q) ||
                        ((state_q == ST_WAIT) && tmr_done_c);
  assign decide_c     = (state_q == ST_IDLE) || completing_c;

  // The requester finishing this cycle still holds its request; it is not new.
  assign if_pend_c = if_req   && !(completing_c && (own_q == OWN_IF));
  assign dm_pend_c = dm_req_c && !(completing_c && (own_q == OWN_DM));

  assign gnt_if_c = decide_c && if_pend_c &&
                    (!dm_pend_c || (starve_q == STARVE_W'(STARVE_MAX)));
  assign gnt_dm_c = decide_c && dm_pend_c && !gnt_if_c;

  // Read data lands next cycle: registered rdy must be raised now.
  assign rd_fin_c = (((state_q == ST_ISSUE) && !wr_q) ||
                     ((state_q == ST_WAIT) && !tmr_done_c)) && tmr_pre_done_c;

  assign tmr_load = (state_q == ST_ISSUE) && !wr_q;
  assign tmr_inc  = (state_q == ST_WAIT) && !tmr_done_c;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      own_q     <= OWN_IF;
      wr_q      <= 1'b0;
      starve_q  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      if_rdy    <= 1'b0;
      dm_rdy    <= 1'b0;
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      wr_q      <= wr_d;
      starve_q  <= starve_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_re    <= re_d;
      mem_we    <= we_d;
      if_rdy    <= if_rdy_d;
      dm_rdy    <= dm_rdy_d;
    end
  end

  // Next-state, grant latching and registered-output decode.
  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    wr_d     = wr_q;
    starve_d = starve_q;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    re_d     = 1'b0;
    we_d     = 1'b0;
    if_rdy_d = 1'b0;
    dm_rdy_d = 1'b0;

    if (decide_c) begin
      state_d = (gnt_if_c || gnt_dm_c) ? ST_ISSUE : ST_IDLE;
    end else if (state_q == ST_ISSUE) begin
      state_d = ST_WAIT;
    end

    if (gnt_if_c) begin
      own_d  = OWN_IF;
      wr_d   = 1'b0;
      addr_d = if_addr;
      re_d   = 1'b1;
    end else if (gnt_dm_c) begin
      // re and we together are resolved as a write.
      own_d    = OWN_DM;
      wr_d     = dm_we;
      addr_d   = dm_addr;
      wdata_d  = dm_wdata;
      re_d     = !dm_we;
      we_d     = dm_we;
      dm_rdy_d = dm_we;
    end

    if (rd_fin_c) begin
      if (own_q == OWN_IF) begin
        if_rdy_d = 1'b1;
      end else begin
        dm_rdy_d = 1'b1;
      end
    end

    if (!if_req || gnt_if_c) begin
      starve_d = '0;
    end else if (gnt_dm_c) begin
      starve_d = sat_inc(starve_q, STARVE_W'(STARVE_MAX));
    end
  end

  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign stall_if  = if_req & ~if_rdy;
  assign stall_mem = dm_req_c & ~dm_rdy;

`ifdef MEM_ARB_PERF_EN
  // Saturating stall-cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_stall <= '0;
      perf_dm_stall <= '0;
    end else begin
      if (stall_if && (perf_if_stall != 16'hFFFF)) begin
        perf_if_stall <= perf_if_stall + 16'd1;
      end
      if (stall_mem && (perf_dm_stall != 16'hFFFF)) begin
        perf_dm_stall <= perf_dm_stall + 16'd1;
      end
    end
  end
`else
  // Stall counters are not built.
`endif

`ifndef SYNTHESIS
  // Simultaneous read and write from the MEM stage is a requester bug.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(dm_re && dm_we))
        else $error("mem_arbiter: dm_re and dm_we both high, handled as write");
    end
  end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates a single-port, fixed-latency unified memory between the fetch stage (IF, read-only) and the MEM stage (data read/write) of the 16-bit pipelined CPU.
- Sequences each access: latch, issue strobe, wait for latency, return data.
- Generates per-requester ready pulses and stall signals for the pipeline control.
- Sits between the cpu pipeline registers and the memory macro.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MEM_LAT, 2, cycles from issue strobe to valid mem_rdata (legal range 1..7)
STARVE_MAX, 4, consecutive DM grants that may be made while IF is waiting before IF is forced to win (range 1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch read request; held until if_rdy
if_addr  in  ADDR_W  fetch address
if_rdy  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  DATA_W  fetch data (mem_rdata pass-through)
dm_re  in  1  data read request; held until dm_rdy
dm_we  in  1  data write request; held until dm_rdy
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_rdy  out  1  one-cycle pulse: data access complete
dm_rdata  out  DATA_W  read data (mem_rdata pass-through)
mem_addr  out  ADDR_W  registered memory address
mem_re  out  1  registered read strobe, one cycle per read
mem_we  out  1  registered write strobe, one cycle per write
mem_wdata  out  DATA_W  registered write data
mem_rdata  in  DATA_W  memory read data
stall_if  out  1  if_req & ~if_rdy (combinational)
stall_mem  out  1  (dm_re|dm_we) & ~dm_rdy (combinational)

Behaviour:
- Reset (asynchronous, active-low, clock clk) forces:
  - state IDLE, starve_cnt 0, lat_cnt 0;
  - mem_addr/mem_wdata 0, mem_re/mem_we 0, if_rdy/dm_rdy 0.
- Reset mid-access abandons the access; no ready pulse is produced for it.
- States: IDLE, ISSUE, WAIT.
- Decision point: any cycle in IDLE, or the completion cycle of the current access.
  - If any request is pending and not completing this cycle, latch owner/addr/wdata/dir and go to ISSUE next cycle. Otherwise go to IDLE.
  - Back-to-back issue is allowed: ISSUE may follow a completion cycle directly.
- ISSUE (exactly one cycle): mem_re or mem_we = 1, mem_addr = latched address.
  - Write: dm_rdy = 1 in this same cycle (completion cycle).
  - Read: go to WAIT with lat_cnt = 1.
- WAIT: lat_cnt increments each cycle. In the cycle MEM_LAT cycles after ISSUE, the owner's rdy = 1 and its rdata = mem_rdata; that cycle is the completion cycle.
- Latency from request (arbiter IDLE) to rdy:
  - read: 1+MEM_LAT cycles;
  - write: 1 cycle.
- Arbitration when both are pending:
  - DM wins, unless starve_cnt == STARVE_MAX, in which case IF wins.
  - starve_cnt increments on each DM grant while if_req = 1.
  - starve_cnt clears on an IF grant, or in any cycle with if_req = 0.
  - starve_cnt saturates at STARVE_MAX.
- rdata of the non-owner: don't-care. Verification checks rdata only when rdy = 1.
- Requester rules:
  - Request signals and addresses stay stable until rdy.
  - Deasserting a request before rdy is illegal.
  - dm_re & dm_we together is illegal: treated as a write, and a simulation-only assertion fires.
- Requests are sampled only at decision points. A request appearing mid-access waits.
- The owner's request still high in the cycle after its rdy counts as a new request.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_if_stall [15:0] and perf_dm_stall [15:0].
  - Each counts cycles with stall_if / stall_mem high.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: those ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, ISSUE, WAIT);
  - owner encoding (OWN_IF = 0, OWN_DM = 1);
  - default MEM_LAT and STARVE_MAX constants.
- One sub-module: mem_arb_lat_timer.
  - Loadable 3-bit counter with a done flag at MEM_LAT.
  - Instantiated once.

Test Plan:
- MEM_LAT=2, if_req alone at addr 16'h0004, mem returns 16'hA5A5 → mem_re in cycle 1, if_rdy + if_rdata=A5A5 in cycle 3, stall_if high in cycles 0–2.
- dm_we alone, addr 16'h0010, wdata 16'h1234 → mem_we=1, mem_addr=0010, mem_wdata=1234 in cycle 1 with dm_rdy the same cycle; no mem_re.
- if_req and dm_re asserted together and held → DM issued first, IF issued in the cycle after dm_rdy; no idle cycle between the two accesses.
- STARVE_MAX=4, dm_re continuously re-asserted and if_req held → exactly 4 DM grants, then an IF grant, then DM resumes; starve_cnt back to 0.
- rst_n pulled low during WAIT of a read → all outputs 0 immediately, no rdy pulse; after release a new if_req completes normally in 1+MEM_LAT cycles.
- MEM_ARB_PERF_EN defined, 10-cycle stall_mem window → perf_dm_stall=10; preload near saturation, confirm the counter holds at 16'hFFFF.
